serial_sort_controller: RTL
===========================

# serial_sort_controller

Frame-level sequencer for the `fast_serial_sort` insertion-sort cell chain. It accepts a frame of up to SIZE unsorted words on a valid/ready stream and drives the sorter's enable/write pins to insert them. It then drains the sorted words on a second valid/ready stream with backpressure and clears the chain before the next frame. It sits beside `fast_serial_sort` in the sort wrapper and owns every sorter control pin.

## Interface
- DATA_WIDTH, 8, word width; must match the sorter.
- SIZE, 3, sorter depth; this is the maximum frame length.
- CNT_W (localparam), $clog2(SIZE+1), width of the element counter.

- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  an unsorted word is offered.
- in_ready  output  1  the controller can accept a word.
- in_data  input  DATA_WIDTH  unsorted word.
- in_last  input  1  marks the final word of the frame.
- out_valid  output  1  a sorted word is presented.
- out_ready  input  1  the consumer accepts the word.
- out_data  output  DATA_WIDTH  sorted word.
- out_last  output  1  marks the final sorted word of the frame.
- busy  output  1  high whenever the state is not LOAD or the LOAD count is nonzero.
- frame_err  output  1  one-cycle pulse: SIZE words were accepted without in_last.
- sort_reset  output  1  to the sorter's reset.
- sort_enable  output  1  to the sorter's enable.
- sort_write  output  1  to the sorter's write.
- sort_unsorted_data  output  DATA_WIDTH  to the sorter's unsorted_data.
- sort_sorted_data  input  DATA_WIDTH  from the sorter's sorted_data.

## Operation
- The FSM has three states: CLEAR, LOAD and DRAIN. Reset forces CLEAR with count = 0.
- **CLEAR** (exactly 1 cycle):
  - sort_reset = 1, sort_enable = 0, in_ready = 0, out_valid = 0.
  - Next state is LOAD.
- **LOAD**:
  - in_ready = 1.
  - sort_unsorted_data = in_data, passed combinationally.
  - sort_write = 1.
  - sort_enable = in_valid & in_ready.
  - Each accepted word increments count.
  - If the accepted word has in_last = 1, or count+1 == SIZE, the next state is DRAIN and count holds the frame length.
  - If count+1 == SIZE and in_last = 0, frame_err pulses in the same cycle. The frame closes at SIZE words. Following words begin the next frame.
- **DRAIN**:
  - out_valid = 1.
  - out_data = sort_sorted_data, passed combinationally; the sorter output is already registered.
  - sort_write = 0.
  - sort_enable = out_valid & out_ready, which pops one word and shifts the chain.
  - Each pop decrements count.
  - out_last = (count == 1).
  - A pop with out_last = 1 moves the FSM to CLEAR.
- Outside the cases above, sort_enable = 0, sort_write = 0, sort_unsorted_data = 0 and out_data = 0.
- Words are emitted in the chain's order: ascending, cell 0 first. The controller never reorders or buffers data.

## Timing
- Reset values (the state is CLEAR):
  - in_ready = 0, out_valid = 0, out_last = 0, frame_err = 0.
  - sort_reset = 1, sort_enable = 0, sort_write = 0.
  - busy = 1.
- After reset deasserts, CLEAR lasts 1 cycle, then LOAD. in_ready is first high 1 cycle after reset deasserts.
- Load latency:
  - 1 word per cycle while in_valid is held.
  - out_valid rises the cycle after the final accept.
- Drain:
  - 1 word per cycle while out_ready is held.
  - out_valid/out_data/out_last stay stable while out_ready = 0.
- Frame period for N words with no stalls: N + N + 1 cycles.
- Handshake stability: in_ready never drops while the FSM is in LOAD. in_valid without in_ready has no effect.
- Simultaneous events: in_ready and out_valid are never both high, so load and drain never overlap.
- Reset mid-frame:
  - Synchronous return to CLEAR.
  - The partial frame is discarded and the sorter is cleared by the CLEAR pulse.
  - No out_last is emitted for the discarded frame.
- A single-word frame (in_last on the first word) drains 1 word with out_last = 1.

## Structure
- Package serial_sort_pkg holds:
  - the state enum typedef {CLEAR, LOAD, DRAIN};
  - the default DATA_WIDTH/SIZE constants shared with the wrapper.
- No sub-module: one FSM plus one CNT_W counter.
- The wrapper serial_sort_top instantiates the controller and fast_serial_sort and connects the sort_* pins.

## Test plan
- Reset, then frame {5,2,9} (SIZE=3, last on 9), out_ready = 1:
  - out stream is 2,5,9 with out_last on 9;
  - out_valid rises 1 cycle after the accept of 9;
  - in_ready returns 2 cycles after the pop of 9.
- Frame {7} with in_last: single output 7 with out_last = 1, followed by 1 CLEAR cycle with sort_reset = 1.
- Frame {3,1,2} with no in_last: frame_err pulses on the accept of 2, out stream is 1,2,3, and the next word starts a new frame.
- Frame {4,8} drained with out_ready toggling 1,0,0,1: out_data = 4 is held stable through the stall, then 8 follows; sort_enable is high only on handshake cycles.
- reset asserted after accepting {6,1}: the next cycle is CLEAR. Then frame {9,0} returns 0,9, with no residue from 6,1.

Source files
------------

// File: rtl/serial_sort_pkg.sv
// Shared definitions for the serial sort controller and its wrapper.
package serial_sort_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_SIZE       = 3;

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        DRAIN
    } state_t;

endpackage

// File: rtl/serial_sort_controller.sv
// Frame sequencer for the fast_serial_sort cell chain: loads a frame of
// unsorted words, drains the sorted words with backpressure, then clears
// the chain before accepting the next frame.
module serial_sort_controller
    import serial_sort_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SIZE       = DEFAULT_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  sort_reset,
    output logic                  sort_enable,
    output logic                  sort_write,
    output logic [DATA_WIDTH-1:0] sort_unsorted_data,
    input  logic [DATA_WIDTH-1:0] sort_sorted_data
);

    localparam int CNT_W = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;

    // State and element counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state, counter update and all sorter/stream control outputs
    always_comb begin
        state_d            = state_q;
        count_d            = count_q;
        count_inc          = count_q + ONE_C;
        in_ready           = 1'b0;
        out_valid          = 1'b0;
        out_data           = '0;
        out_last           = 1'b0;
        frame_err          = 1'b0;
        sort_reset         = 1'b0;
        sort_enable        = 1'b0;
        sort_write         = 1'b0;
        sort_unsorted_data = '0;
        busy               = (state_q != LOAD) || (count_q != '0);

        unique case (state_q)
            CLEAR: begin
                sort_reset = 1'b1;
                count_d    = '0;
                state_d    = LOAD;
            end
            LOAD: begin
                in_ready           = 1'b1;
                sort_write         = 1'b1;
                sort_unsorted_data = in_data;
                sort_enable        = in_valid;
                if (in_valid) begin
                    count_d = count_inc;
                    if (in_last || (count_inc == SIZE_C)) begin
                        state_d = DRAIN;
                    end
                    if ((count_inc == SIZE_C) && !in_last) begin
                        frame_err = 1'b1;
                    end
                end
            end
            DRAIN: begin
                out_valid   = 1'b1;
                out_data    = sort_sorted_data;
                out_last    = (count_q == ONE_C);
                sort_enable = out_ready;
                if (out_ready) begin
                    count_d = count_q - ONE_C;
                    if (count_q == ONE_C) begin
                        state_d = CLEAR;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                count_d = '0;
            end
        endcase
    end

endmodule
